// File: rtl/eth_rx_frame.sv
// 10BASE-T Manchester receiver: line edges -> bits -> SFD hunt -> byte stream, with end-of-frame
// length/error report on loss of carrier. No backpressure: bytes are strobed as they arrive.
module eth_rx_frame #(
  parameter int OVS     = 8,
  parameter int SILENCE = 14,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic [LEN_W-1:0] rx_len,
  output logic             rx_err,
  output logic             crs
);

  localparam int SC_W    = $clog2(SILENCE + 1);
  localparam int MID_MIN = 3 * OVS / 4;

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_DATA, S_END} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [SC_W-1:0]  scnt_q, scnt_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [LEN_W-1:0] bytecnt_q, bytecnt_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_sof_q, rx_sof_d;
  logic             rx_eof_q, rx_eof_d;
  logic [LEN_W-1:0] rx_len_q, rx_len_d;
  logic             rx_err_q, rx_err_d;
  logic             crs_q, crs_d;

  logic             edge_det, lvl, accept, lost;
  logic [7:0]       shifted;

  always_comb begin
    edge_det   = sync_q[1] ^ prev_q;
    lvl        = sync_q[1];
    accept     = edge_det && ((state_q == S_IDLE) || (scnt_q >= SC_W'(MID_MIN)));
    lost       = (scnt_q == SC_W'(SILENCE));
    shifted    = {lvl, sreg_q[7:1]};

    state_d    = state_q;
    sync_d     = {sync_q[0], rxd};
    prev_d     = sync_q[1];
    scnt_d     = accept ? '0 : (lost ? scnt_q : scnt_q + SC_W'(1));
    sreg_d     = sreg_q;
    bitcnt_d   = bitcnt_q;
    bytecnt_d  = bytecnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_sof_d   = 1'b0;
    rx_eof_d   = 1'b0;
    rx_len_d   = rx_len_q;
    rx_err_d   = rx_err_q;
    crs_d      = crs_q;

    case (state_q)
      S_IDLE: begin
        crs_d = 1'b0;
        if (edge_det) begin
          state_d = S_HUNT;
          crs_d   = 1'b1;
          sreg_d  = {lvl, 7'b0};
        end
      end
      S_HUNT: begin
        if (accept) begin
          sreg_d = shifted;
          if (shifted == 8'hD5) begin
            state_d   = S_DATA;
            bitcnt_d  = '0;
            bytecnt_d = '0;
          end
        end else if (lost) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        // A received bit takes priority; its edge restarts the silence count anyway.
        if (accept) begin
          sreg_d   = shifted;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (bytecnt_q < LEN_W'(MAX_LEN)) begin
              rx_data_d  = shifted;
              rx_valid_d = 1'b1;
              rx_sof_d   = (bytecnt_q == '0);
            end
            if (bytecnt_q <= LEN_W'(MAX_LEN))
              bytecnt_d = bytecnt_q + LEN_W'(1);
          end
        end else if (lost) begin
          state_d = S_END;
        end
      end
      S_END: begin
        rx_eof_d = 1'b1;
        rx_len_d = (bytecnt_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bytecnt_q;
        rx_err_d = (bitcnt_q != 3'd0) || (bytecnt_q > LEN_W'(MAX_LEN));
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchronizer resets to the idle line level so reset release does not fake a carrier edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      scnt_q     <= '0;
      sreg_q     <= '0;
      bitcnt_q   <= '0;
      bytecnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_sof_q   <= 1'b0;
      rx_eof_q   <= 1'b0;
      rx_len_q   <= '0;
      rx_err_q   <= 1'b0;
      crs_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      scnt_q     <= scnt_d;
      sreg_q     <= sreg_d;
      bitcnt_q   <= bitcnt_d;
      bytecnt_q  <= bytecnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_sof_q   <= rx_sof_d;
      rx_eof_q   <= rx_eof_d;
      rx_len_q   <= rx_len_d;
      rx_err_q   <= rx_err_d;
      crs_q      <= crs_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_sof   = rx_sof_q;
  assign rx_eof   = rx_eof_q;
  assign rx_len   = rx_len_q;
  assign rx_err   = rx_err_q;
  assign crs      = crs_q;

endmodule
